seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Downstream display stage of the calculator. Takes the 8-digit hex result word (plus blank/dp masks)
//  and time-multiplexes it onto the common-anode 8-digit 7-segment display (an/seg/dp).
//  Double-buffered: new data is loaded into a shadow set and committed only at a frame boundary (no tearing).
// PARAMETERS
//  DIGIT_CYCLES  100000  clock cycles each digit is lit (1 kHz digit rate, 125 Hz frame at 100 MHz); must be >= 2
// PORTS
//  CLK100MHZ   in   1   system clock, 100 MHz
//  CPU_RESETN  in   1   reset, asynchronous, active-low
//  disp_value  in   32  one hex nibble per digit; digit0 (rightmost) = [3:0], digit7 = [31:28]
//  disp_blank  in   8   1 = digit blanked (anode off, dp off); bit i = digit i
//  disp_dp     in   8   1 = decimal point lit on digit i
//  disp_load   in   1   1-cycle strobe; captures value/blank/dp into the shadow set
//  disp_pending out 1   1 while the shadow set holds data not yet committed
//  frame_tick  out  1   1-cycle pulse, first cycle of each new frame
//  an          out  8   anode enables, active-low, one-hot-low or all-high
//  seg         out  7   segments, active-low, seg = {g,f,e,d,c,b,a}
//  dp          out  1   decimal point, active-low
// BEHAVIOUR
//  Reset (async, CPU_RESETN=0): prescaler=0, idx=0, shadow and active sets: value=0, blank=8'hFF, dp=0;
//   an=8'hFF, seg=7'h7F, dp=1, disp_pending=0, frame_tick=0. State holds while reset is low.
//  Prescaler: counts 0..DIGIT_CYCLES-1 and wraps. At terminal count (TC), idx <= idx+1 mod 8.
//  Frame boundary (FB): cycle where TC && idx==7. On FB: active <= shadow, disp_pending <= 0.
//   frame_tick=1 in the cycle after FB (idx==0, new active set valid).
//  Load: disp_load=1 (no FB in same cycle) -> shadow <= inputs, disp_pending <= 1 next cycle.
//   Repeated loads before FB: last one wins. Active set and display are unchanged until FB.
//   Load coincident with FB: inputs bypass directly to active (and shadow), disp_pending <= 0.
//   Inputs are sampled only on disp_load; they may change freely at other times.
//  Outputs are registered; one cycle of latency from idx/active state:
//   an    = blank[idx] ? 8'hFF : ~(8'b1 << idx)
//   seg   = blank[idx] ? 7'h7F : font(value nibble idx)
//   dp    = (blank[idx] | ~dp_mask[idx]) ? 1 : 0
//  Font (hex, active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
//  Only one anode is ever low. No glitch on an between digits: an and seg update in the same edge.
//  Reset mid-frame: immediate return to reset values; any pending shadow data is discarded.
// TESTING (bench overrides DIGIT_CYCLES=4; frame = 32 cycles)
//  1. Hold CPU_RESETN=0 10 cycles, release -> an=FF seg=7F dp=1 disp_pending=0 for all of frame 0; frame_tick
//     pulses every 32 cycles.
//  2. Load value=32'h0000000D blank=8'hFE dp=0 -> disp_pending=1 until FB; next frame: idx0 slot an=FE
//     seg=21 dp=1; other slots an=FF.
//  3. Load value=32'h0000DEAD blank=8'hF0 dp=8'h04 -> slots 3..0 show seg 21,06,08,21 with an=F7,FB,FD,FE;
//     dp=0 only in the digit-2 slot.
//  4. Load mid-frame, then a second load (value 32'h12345678, blank 00) before FB -> display unchanged
//     until FB; afterwards digits 7..0 = 79,24,30,19,12,02,78,00; first load never shown.
//  5. Assert disp_load exactly on the FB cycle -> new data is shown from the next frame, disp_pending
//     never goes 1, frame_tick asserted.
//  6. Drop CPU_RESETN mid-frame with disp_pending=1 -> an=FF seg=7F dp=1 pending=0 asynchronously; after
//     release the scan restarts at idx 0 and old data is not shown.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode 7-segment scan driver.
// Data is loaded into a shadow set and committed to the active set only at a
// frame boundary, so a frame is never drawn with a mix of old and new digits.
module seg7_scan_driver #(
  parameter int unsigned DIGIT_CYCLES = 100000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [31:0] disp_value,
  input  logic [7:0]  disp_blank,
  input  logic [7:0]  disp_dp,
  input  logic        disp_load,
  output logic        disp_pending,
  output logic        frame_tick,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned PW = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [PW-1:0] TC_VAL = PW'(DIGIT_CYCLES - 1);

  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic [31:0]   sh_value, act_value;
  logic [7:0]    sh_blank, act_blank;
  logic [7:0]    sh_dp, act_dp;

  logic          tc, fb;
  logic [7:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;

  // Active-low hex font, {g,f,e,d,c,b,a}.
  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0:    font = 7'h40;
      4'h1:    font = 7'h79;
      4'h2:    font = 7'h24;
      4'h3:    font = 7'h30;
      4'h4:    font = 7'h19;
      4'h5:    font = 7'h12;
      4'h6:    font = 7'h02;
      4'h7:    font = 7'h78;
      4'h8:    font = 7'h00;
      4'h9:    font = 7'h10;
      4'hA:    font = 7'h08;
      4'hB:    font = 7'h03;
      4'hC:    font = 7'h46;
      4'hD:    font = 7'h21;
      4'hE:    font = 7'h06;
      default: font = 7'h0E;
    endcase
  endfunction

  assign tc = (presc == TC_VAL);
  assign fb = tc && (idx == 3'd7);

  // Digit currently selected by idx, decoded from the active set.
  always_comb begin
    an_nxt  = '1;
    seg_nxt = '1;
    dp_nxt  = 1'b1;
    if (!act_blank[idx]) begin
      an_nxt  = ~(8'b1 << idx);
      seg_nxt = font(act_value[{idx, 2'b00} +: 4]);
      dp_nxt  = ~act_dp[idx];
    end
  end

  // Prescaler and digit index.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      presc <= '0;
      idx   <= '0;
    end else if (tc) begin
      presc <= '0;
      idx   <= idx + 3'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Shadow/active double buffer; a load on the boundary cycle bypasses the
  // shadow so it is shown in the very next frame and never reads as pending.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sh_value     <= '0;
      sh_blank     <= '1;
      sh_dp        <= '0;
      act_value    <= '0;
      act_blank    <= '1;
      act_dp       <= '0;
      disp_pending <= 1'b0;
    end else begin
      if (disp_load) begin
        sh_value <= disp_value;
        sh_blank <= disp_blank;
        sh_dp    <= disp_dp;
      end
      if (fb) begin
        act_value    <= disp_load ? disp_value : sh_value;
        act_blank    <= disp_load ? disp_blank : sh_blank;
        act_dp       <= disp_load ? disp_dp    : sh_dp;
        disp_pending <= 1'b0;
      end else if (disp_load) begin
        disp_pending <= 1'b1;
      end
    end
  end

  // Registered display outputs and frame pulse; an and seg change on the same edge.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      an         <= '1;
      seg        <= '1;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_tick <= fb;
    end
  end

endmodule
